// File: rtl/hazard_match_tracker.sv
// Tracks register addresses through the E/M/W stages. It produces forwarding
// match flags, the load-use stall/flush controls and a saturating stall counter.
module hazard_match_tracker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcE,
    output logic [3:0]       Match,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [3:0] PC_REG = 4'hF;

    logic [3:0]       ra1e_q, ra1e_d;
    logic [3:0]       ra2e_q, ra2e_d;
    logic [3:0]       wa3e_q, wa3e_d;
    logic             regwritee_q, regwritee_d;
    logic             memtorege_q, memtorege_d;
    logic [3:0]       wa3m_q, wa3m_d;
    logic             regwritem_q, regwritem_d;
    logic [3:0]       wa3w_q, wa3w_d;
    logic             regwritew_q, regwritew_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             ldr_stall;
    logic             flush_e;

    always_comb begin
        ldr_stall = memtorege_q & regwritee_q & (wa3e_q != PC_REG) &
                    ((RA1D == wa3e_q) | (RA2D == wa3e_q));
        flush_e   = ldr_stall | PCSrcE;

        // R15 is the PC and is never a forwarding source.
        Match[3] = (ra1e_q != PC_REG) & (ra1e_q == wa3m_q);
        Match[2] = (ra1e_q != PC_REG) & (ra1e_q == wa3w_q);
        Match[1] = (ra2e_q != PC_REG) & (ra2e_q == wa3m_q);
        Match[0] = (ra2e_q != PC_REG) & (ra2e_q == wa3w_q);

        StallF     = ldr_stall;
        StallD     = ldr_stall;
        FlushD     = PCSrcE;
        FlushE     = flush_e;
        RegWriteM  = regwritem_q;
        RegWriteW  = regwritew_q;
        StallCount = stall_cnt_q;
    end

    always_comb begin
        ra1e_d      = RA1D;
        ra2e_d      = RA2D;
        wa3e_d      = WA3D;
        regwritee_d = RegWriteD;
        memtorege_d = MemtoRegD;
        if (flush_e) begin
            ra1e_d      = '0;
            ra2e_d      = '0;
            wa3e_d      = '0;
            regwritee_d = 1'b0;
            memtorege_d = 1'b0;
        end

        wa3m_d      = wa3e_q;
        regwritem_d = regwritee_q;
        wa3w_d      = wa3m_q;
        regwritew_d = regwritem_q;

        stall_cnt_d = stall_cnt_q;
        if (ldr_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1e_q      <= '0;
            ra2e_q      <= '0;
            wa3e_q      <= '0;
            regwritee_q <= 1'b0;
            memtorege_q <= 1'b0;
            wa3m_q      <= '0;
            regwritem_q <= 1'b0;
            wa3w_q      <= '0;
            regwritew_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ra1e_q      <= ra1e_d;
            ra2e_q      <= ra2e_d;
            wa3e_q      <= wa3e_d;
            regwritee_q <= regwritee_d;
            memtorege_q <= memtorege_d;
            wa3m_q      <= wa3m_d;
            regwritem_q <= regwritem_d;
            wa3w_q      <= wa3w_d;
            regwritew_q <= regwritew_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_match_tracker.sv
// Bench for hazard_match_tracker: directed scenarios plus random traffic checked
// against an instruction-level pipeline model.
module tb_hazard_match_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3D;
    logic       RegWriteD, MemtoRegD, PCSrcE;

    logic [3:0]  Match;
    logic        RegWriteM, RegWriteW, StallF, StallD, FlushD, FlushE;
    logic [15:0] StallCount;

    logic [3:0] s_Match;
    logic       s_RegWriteM, s_RegWriteW, s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic [3:0] s_StallCount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_match_tracker u_dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcE(PCSrcE),
        .Match(Match), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCount(StallCount)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_match_tracker #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcE(PCSrcE),
        .Match(s_Match), .RegWriteM(s_RegWriteM), .RegWriteW(s_RegWriteW),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .StallCount(s_StallCount)
    );

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
        logic       rw;
        logic       mtr;
    } instr_t;

    instr_t      me, mm, mw;
    int unsigned cnt, cnt_s;

    function automatic void model_reset();
        me = '0; mm = '0; mw = '0;
        cnt = 0; cnt_s = 0;
    endfunction

    function automatic logic exp_ldr();
        return me.mtr && me.rw && (me.wa3 != 4'hF) && ((RA1D == me.wa3) || (RA2D == me.wa3));
    endfunction

    function automatic logic [3:0] exp_match();
        logic [3:0] r;
        r[3] = (me.ra1 != 4'hF) && (me.ra1 == mm.wa3);
        r[2] = (me.ra1 != 4'hF) && (me.ra1 == mw.wa3);
        r[1] = (me.ra2 != 4'hF) && (me.ra2 == mm.wa3);
        r[0] = (me.ra2 != 4'hF) && (me.ra2 == mw.wa3);
        return r;
    endfunction

    task automatic set_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                         input logic rw, input logic mtr, input logic pcs);
        RA1D = a1; RA2D = a2; WA3D = w; RegWriteD = rw; MemtoRegD = mtr; PCSrcE = pcs;
    endtask

    // Advance the model with the current inputs, then move past the next edge.
    task automatic tick();
        instr_t d;
        logic   st;
        if (reset) begin
            st = exp_ldr();
            d.ra1 = RA1D; d.ra2 = RA2D; d.wa3 = WA3D; d.rw = RegWriteD; d.mtr = MemtoRegD;
            mw = mm;
            mm = me;
            me = (st || PCSrcE) ? instr_t'('0) : d;
            if (st) begin
                if (cnt < 65535) cnt++;
                if (cnt_s < 15) cnt_s++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        set_d(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_d(0, 0, 0, 1, 1, 1);
        #1;
        n_cmp++; if (RegWriteM !== 1'b0 || RegWriteW !== 1'b0) begin n_bad++;
            $display("FAIL reset_regwrite: got %b%b want 00", RegWriteM, RegWriteW); end
        n_cmp++; if (StallF !== 1'b0 || StallD !== 1'b0) begin n_bad++;
            $display("FAIL reset_stall: got %b%b want 00", StallF, StallD); end
        n_cmp++; if (StallCount !== 16'h0) begin n_bad++;
            $display("FAIL reset_count: got %h want 0000", StallCount); end
        n_cmp++; if (Match !== 4'b1111) begin n_bad++;
            $display("FAIL reset_match: got %b want 1111", Match); end
        n_cmp++; if (FlushE !== 1'b1 || FlushD !== 1'b1) begin n_bad++;
            $display("FAIL reset_flush_pcsrc1: got %b%b want 11", FlushD, FlushE); end
        PCSrcE = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (FlushE !== 1'b0 || FlushD !== 1'b0 || RegWriteM !== 1'b0) begin n_bad++;
            $display("FAIL reset_hold: got flush %b%b rwm %b want 00 0", FlushD, FlushE, RegWriteM); end
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_d(0, 0, 3, 1, 0, 0); tick();
        set_d(3, 5, 7, 1, 0, 0); tick();
        n_cmp++; if (Match !== 4'b1000 || RegWriteM !== 1'b1) begin n_bad++;
            $display("FAIL alu_fwd_m: got match %b rwm %b want 1000 1", Match, RegWriteM); end
        tick();
        n_cmp++; if (Match !== 4'b0100 || RegWriteW !== 1'b1) begin n_bad++;
            $display("FAIL alu_fwd_w: got match %b rww %b want 0100 1", Match, RegWriteW); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(9, 9, 2, 1, 1, 0); tick();
        set_d(5, 2, 6, 1, 0, 0);
        #1;
        n_cmp++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin n_bad++;
            $display("FAIL load_use_stall: got %b want 1110", {StallF, StallD, FlushE, FlushD}); end
        tick();
        n_cmp++; if (StallF !== 1'b0 || FlushE !== 1'b0 || StallCount !== 16'd1) begin n_bad++;
            $display("FAIL load_use_after: got stall %b flushE %b cnt %0d want 0 0 1", StallF, FlushE, StallCount); end
        tick();
        n_cmp++; if (RegWriteM !== 1'b0 || StallF !== 1'b0) begin n_bad++;
            $display("FAIL load_use_bubble: got rwm %b stall %b want 0 0", RegWriteM, StallF); end
    endtask

    task automatic test_pc_exclusion();
        do_reset();
        set_d(0, 0, 15, 1, 0, 0); tick();
        set_d(15, 15, 1, 0, 0, 0); tick();
        n_cmp++; if (Match !== 4'b0000 || RegWriteM !== 1'b1) begin n_bad++;
            $display("FAIL pc_exclusion: got match %b rwm %b want 0000 1", Match, RegWriteM); end
    endtask

    task automatic test_branch_load();
        do_reset();
        set_d(0, 0, 2, 1, 1, 0); tick();
        set_d(2, 0, 7, 1, 0, 1);
        #1;
        n_cmp++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin n_bad++;
            $display("FAIL branch_load: got %b want 1111", {FlushD, FlushE, StallF, StallD}); end
        tick();
        PCSrcE = 1'b0;
        #1;
        n_cmp++; if (StallF !== 1'b0 || FlushE !== 1'b0) begin n_bad++;
            $display("FAIL branch_load_next: got stall %b flushE %b want 0 0", StallF, FlushE); end
        tick();
        n_cmp++; if (RegWriteM !== 1'b0 || RegWriteW !== 1'b1) begin n_bad++;
            $display("FAIL branch_load_bubble: got rwm %b rww %b want 0 1", RegWriteM, RegWriteW); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_d(2, 2, 2, 1, 1, 0);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 30) begin
                n_cmp++; if (s_StallCount !== 4'hF || StallCount !== 16'd15) begin n_bad++;
                    $display("FAIL sat_reach: got %h/%0d want f/15", s_StallCount, StallCount); end
            end
        end
        n_cmp++; if (s_StallCount !== 4'hF) begin n_bad++;
            $display("FAIL sat_no_wrap: got %h want f", s_StallCount); end
        n_cmp++; if (StallCount !== 16'd20) begin n_bad++;
            $display("FAIL sat_wide_count: got %0d want 20", StallCount); end
    endtask

    task automatic test_async_reset();
        set_d(0, 0, 4, 1, 0, 0); tick();
        set_d(0, 0, 2, 1, 1, 0); tick();
        set_d(2, 3, 6, 1, 0, 0);
        #1;
        n_cmp++; if (StallF !== 1'b1 || RegWriteM !== 1'b1 || StallCount !== 16'(cnt)) begin n_bad++;
            $display("FAIL async_pre: got stall %b rwm %b cnt %0d want 1 1 %0d", StallF, RegWriteM, StallCount, cnt); end
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({RegWriteM, RegWriteW, StallF} !== 3'b000 || StallCount !== 16'h0 || s_StallCount !== 4'h0) begin n_bad++;
            $display("FAIL async_reset: got rw %b%b stall %b cnt %0d want 00 0 0", RegWriteM, RegWriteW, StallF, StallCount); end
        n_cmp++; if (Match !== 4'b1111) begin n_bad++;
            $display("FAIL async_match: got %b want 1111", Match); end
        #2;
        reset = 1'b1;
        tick();
        n_cmp++; if (RegWriteM !== 1'b0 || StallF !== 1'b0 || StallCount !== 16'h0) begin n_bad++;
            $display("FAIL async_restart: got rwm %b stall %b cnt %0d want 0 0 0", RegWriteM, StallF, StallCount); end
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [3:0] em;
        logic       el;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_d(rreg(), rreg(), rreg(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            #1;
            em = exp_match();
            el = exp_ldr();
            n_cmp++; if (Match !== em || s_Match !== em) begin n_bad++;
                $display("FAIL rnd_match[%0d]: got %b/%b want %b", i, Match, s_Match, em); end
            n_cmp++; if ({RegWriteM, RegWriteW} !== {mm.rw, mw.rw}) begin n_bad++;
                $display("FAIL rnd_regwrite[%0d]: got %b%b want %b%b", i, RegWriteM, RegWriteW, mm.rw, mw.rw); end
            n_cmp++; if ({StallF, StallD, FlushD, FlushE} !== {el, el, PCSrcE, el | PCSrcE}) begin n_bad++;
                $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {StallF, StallD, FlushD, FlushE}, {el, el, PCSrcE, el | PCSrcE}); end
            n_cmp++; if (StallCount !== 16'(cnt) || s_StallCount !== 4'(cnt_s)) begin n_bad++;
                $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d/%0d", i, StallCount, s_StallCount, cnt, cnt_s); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_pc_exclusion();
        test_branch_load();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_match_tracker.md
HAZARD_MATCH_TRACKER -- requirements
Module: hazard_match_tracker

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- RA1D  input  4  decode-stage source register 1
- RA2D  input  4  decode-stage source register 2
- WA3D  input  4  decode-stage destination register
- RegWriteD  input  1  decode instruction writes WA3D
- MemtoRegD  input  1  decode instruction is a load
- PCSrcE  input  1  taken branch resolved in execute
- Match  output  4  {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W}
- RegWriteM  output  1  memory-stage write enable, tracked copy
- RegWriteW  output  1  writeback-stage write enable, tracked copy
- StallF  output  1  hold fetch PC
- StallD  output  1  hold the F/D pipeline register
- FlushD  output  1  clear the F/D pipeline register
- FlushE  output  1  insert a bubble into execute
- StallCount  output  16  saturating count of load-use stall cycles

Function
REQ-002 The block SHALL hold the shadow registers RA1E, RA2E, WA3E, RegWriteE and MemtoRegE (execute stage), WA3M and RegWriteM (memory stage), and WA3W and RegWriteW (writeback stage).
REQ-003 On each clock edge, the block SHALL shift D->E, E->M and M->W.
REQ-004 When FlushE=1 at an edge, the block SHALL load the E stage with RA1E=RA2E=WA3E=0 and RegWriteE=MemtoRegE=0; M and W SHALL still shift.
REQ-005 The block SHALL compute Match combinationally:
- Match_1E_M = (RA1E==WA3M)
- Match_1E_W = (RA1E==WA3W)
- Match_2E_M = (RA2E==WA3M)
- Match_2E_W = (RA2E==WA3W)
REQ-006 Each Match bit SHALL be forced to 0 when the compared source register equals 4'hF, because R15 (PC) is never forwarded.
REQ-007 Match bits SHALL NOT be qualified by RegWrite; the consumer qualifies them with RegWriteM and RegWriteW.
REQ-008 The block SHALL compute LDRstall = MemtoRegE & RegWriteE & (WA3E!=4'hF) & ((RA1D==WA3E) | (RA2D==WA3E)).
REQ-009 The stall and flush outputs SHALL be: StallF = StallD = LDRstall; FlushE = LDRstall | PCSrcE; FlushD = PCSrcE.
REQ-010 When LDRstall and PCSrcE are both 1, the outputs SHALL be StallF=StallD=1 and FlushD=FlushE=1; the flush takes priority for the D register, and the consumer applies the flush over the stall.
REQ-011 A load-use stall SHALL last exactly one cycle: after the bubble, MemtoRegE=0, so LDRstall deasserts on the next cycle.
REQ-012 StallCount SHALL increment by 1 on every edge where LDRstall=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-013 Match, LDRstall, StallF, StallD, FlushD and FlushE SHALL be purely combinational from the current state and the D/E inputs, with zero-cycle latency.
REQ-014 Stage registers SHALL advance on every edge; this block never stalls itself. Holding the D stage is the consumer's job, via StallD.

Reset
REQ-015 While reset=0, all stage registers SHALL be 0 and StallCount SHALL be 0, asynchronously and independent of clk.
REQ-016 During reset, with E, M and W all zero, the outputs SHALL be RegWriteM=RegWriteW=0, LDRstall=0, StallF=StallD=0, and FlushD=FlushE=PCSrcE.
REQ-017 Match SHALL equal the register-0 compare result during reset: Match=4'b1111 when RA1E=RA2E=0, because WA3M=WA3W=0.
REQ-018 The consumer SHALL ignore Match during reset; it does so because RegWrite is 0.
REQ-019 Asserting reset mid-stall SHALL clear the pending bubble and the counter, and tracking SHALL restart from an empty pipeline on the first edge after reset=1.

Verification
REQ-020 ALU forward: an instruction writing R3, then an instruction reading R3 as Rn -> one cycle later, Match=4'b1000 and RegWriteM=1; one cycle after that, Match=4'b0100 and RegWriteW=1.
REQ-021 Load-use: LDR R2 in E, and an instruction reading R2 as Rm in D -> StallF=StallD=FlushE=1 for one cycle; the next cycle E holds a bubble, LDRstall=0 and StallCount=1.
REQ-022 PC exclusion: an instruction writing R15 (WA3M=F), then an instruction reading R15 in E -> Match=4'b0000.
REQ-023 Branch plus load-use in the same cycle (PCSrcE=1, LDRstall=1) -> FlushD=1, FlushE=1 and StallF=1; the next cycle E is a bubble.
REQ-024 Saturation: hold a load-use pattern for 65540 stall events -> StallCount=16'hFFFF, with no wrap to 0.
REQ-025 Async reset: pull reset low mid-cycle while a stall is active -> immediately RegWriteM=RegWriteW=0, StallCount=0 and LDRstall=0, with no clk edge required.
